// File: rtl/memory_operand_fetch.sv
// Operand fetch stage: resolves up to three 64-bit operands through one in-order
// D-memory read port and holds the front of the pipeline until they are ready.
module memory_operand_fetch #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validIn,
    input  logic              stallIn,
    input  logic              isMemoryAccessSrc1In,
    input  logic              isMemoryAccessSrc2In,
    input  logic              isMemoryAccessDestIn,
    input  logic [ADDR_W-1:0] memoryAddressSrc1In,
    input  logic [ADDR_W-1:0] memoryAddressSrc2In,
    input  logic [ADDR_W-1:0] memoryAddressDestIn,
    input  logic [DATA_W-1:0] operand1ValIn,
    input  logic [DATA_W-1:0] operand2ValIn,
    input  logic [DATA_W-1:0] destRegValueIn,
    output logic              memReqOut,
    output logic [ADDR_W-1:0] memAddrOut,
    input  logic              memReadyIn,
    input  logic [DATA_W-1:0] memDataIn,
    input  logic              memDataValidIn,
    output logic [DATA_W-1:0] operand1ValOut,
    output logic [DATA_W-1:0] operand2ValOut,
    output logic [DATA_W-1:0] destMemValueOut,
    output logic              fetchDoneOut,
    output logic              stallOut,
    output logic              fetchErrorOut
);

    typedef enum logic [2:0] {
        IDLE, REQ_S1, WT_S1, REQ_S2, WT_S2, REQ_D, WT_D, DONE
    } state_t;

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_t              state, nextState;
    logic [TIMER_W-1:0]  timer;
    logic                timedOut, abort;
    logic                flagSrc2, flagDest;
    logic [ADDR_W-1:0]   addrSrc1, addrSrc2, addrDest, nextAddr;

    // First outstanding read in S1, S2, D order; DONE when nothing is left.
    function automatic state_t firstReq(input logic s1, input logic s2, input logic d);
        if (s1)      return REQ_S1;
        else if (s2) return REQ_S2;
        else if (d)  return REQ_D;
        else         return DONE;
    endfunction

    // The timer counts from 0 on entry, so TIMEOUT-1 marks the last cycle allowed.
    assign timedOut = (timer == TIMER_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nextState = state;
        abort     = 1'b0;
        case (state)
            IDLE:   if (validIn && !stallIn)
                        nextState = firstReq(isMemoryAccessSrc1In, isMemoryAccessSrc2In,
                                             isMemoryAccessDestIn);
            REQ_S1: if (memReadyIn) nextState = WT_S1; else if (timedOut) abort = 1'b1;
            REQ_S2: if (memReadyIn) nextState = WT_S2; else if (timedOut) abort = 1'b1;
            REQ_D:  if (memReadyIn) nextState = WT_D;  else if (timedOut) abort = 1'b1;
            WT_S1:  if (memDataValidIn) nextState = firstReq(1'b0, flagSrc2, flagDest);
                    else if (timedOut) abort = 1'b1;
            WT_S2:  if (memDataValidIn) nextState = firstReq(1'b0, 1'b0, flagDest);
                    else if (timedOut) abort = 1'b1;
            WT_D:   if (memDataValidIn) nextState = DONE;
                    else if (timedOut) abort = 1'b1;
            DONE:   if (!stallIn) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    // Addresses come straight from the inputs on the accepting cycle, from the captures after.
    always_comb begin
        nextAddr = '0;
        case (nextState)
            REQ_S1:  nextAddr = (state == IDLE) ? memoryAddressSrc1In : addrSrc1;
            REQ_S2:  nextAddr = (state == IDLE) ? memoryAddressSrc2In : addrSrc2;
            REQ_D:   nextAddr = (state == IDLE) ? memoryAddressDestIn : addrDest;
            default: nextAddr = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            flagSrc2        <= 1'b0;
            flagDest        <= 1'b0;
            addrSrc1        <= '0;
            addrSrc2        <= '0;
            addrDest        <= '0;
            memReqOut       <= 1'b0;
            memAddrOut      <= '0;
            operand1ValOut  <= '0;
            operand2ValOut  <= '0;
            destMemValueOut <= '0;
            fetchDoneOut    <= 1'b0;
            stallOut        <= 1'b0;
            fetchErrorOut   <= 1'b0;
        end else begin
            state         <= nextState;
            memReqOut     <= (nextState inside {REQ_S1, REQ_S2, REQ_D});
            memAddrOut    <= nextAddr;
            stallOut      <= (nextState != IDLE);
            fetchDoneOut  <= (nextState == DONE);
            fetchErrorOut <= abort;

            if (nextState != state)
                timer <= '0;
            else if (state != IDLE && state != DONE)
                timer <= timer + TIMER_W'(1);

            if (state == IDLE && validIn && !stallIn) begin
                flagSrc2        <= isMemoryAccessSrc2In;
                flagDest        <= isMemoryAccessDestIn;
                addrSrc1        <= memoryAddressSrc1In;
                addrSrc2        <= memoryAddressSrc2In;
                addrDest        <= memoryAddressDestIn;
                operand1ValOut  <= operand1ValIn;
                operand2ValOut  <= operand2ValIn;
                destMemValueOut <= destRegValueIn;
            end

            if (memDataValidIn) begin
                case (state)
                    WT_S1:   operand1ValOut  <= memDataIn;
                    WT_S2:   operand2ValOut  <= memDataIn;
                    WT_D:    destMemValueOut <= memDataIn;
                    default: ;
                endcase
            end

            // An aborted fetch must not leave partially fetched operands visible.
            if (abort) begin
                operand1ValOut  <= '0;
                operand2ValOut  <= '0;
                destMemValueOut <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_operand_fetch.sv
// Directed bench for memory_operand_fetch: a vector table driven through a
// zero-wait memory responder, plus hand sequences for stall, timeout and reset.
module tb_memory_operand_fetch;

    localparam logic [63:0] MEM_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MEM_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] MEM_C = 64'h8000_0000_0000_0001;
    localparam logic [63:0] MEM_E = 64'h0000_0000_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        validIn = 1'b0, stallIn = 1'b0;
    logic        isMemoryAccessSrc1In = 1'b0, isMemoryAccessSrc2In = 1'b0, isMemoryAccessDestIn = 1'b0;
    logic [63:0] memoryAddressSrc1In = '0, memoryAddressSrc2In = '0, memoryAddressDestIn = '0;
    logic [63:0] operand1ValIn = '0, operand2ValIn = '0, destRegValueIn = '0;
    logic        memReqOut;
    logic [63:0] memAddrOut;
    logic        memReadyIn = 1'b0;
    logic [63:0] memDataIn = '0;
    logic        memDataValidIn = 1'b0;
    logic [63:0] operand1ValOut, operand2ValOut, destMemValueOut;
    logic        fetchDoneOut, stallOut, fetchErrorOut;

    int compared = 0;
    int mismatched = 0;

    memory_operand_fetch #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .stallIn(stallIn),
        .isMemoryAccessSrc1In(isMemoryAccessSrc1In), .isMemoryAccessSrc2In(isMemoryAccessSrc2In),
        .isMemoryAccessDestIn(isMemoryAccessDestIn),
        .memoryAddressSrc1In(memoryAddressSrc1In), .memoryAddressSrc2In(memoryAddressSrc2In),
        .memoryAddressDestIn(memoryAddressDestIn),
        .operand1ValIn(operand1ValIn), .operand2ValIn(operand2ValIn), .destRegValueIn(destRegValueIn),
        .memReqOut(memReqOut), .memAddrOut(memAddrOut), .memReadyIn(memReadyIn),
        .memDataIn(memDataIn), .memDataValidIn(memDataValidIn),
        .operand1ValOut(operand1ValOut), .operand2ValOut(operand2ValOut),
        .destMemValueOut(destMemValueOut), .fetchDoneOut(fetchDoneOut),
        .stallOut(stallOut), .fetchErrorOut(fetchErrorOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s1, s2, d;
        logic [63:0] a1, a2, ad;
        logic [63:0] r1, r2, rd;
        logic [63:0] e1, e2, ed;
        int          nReq;
        logic [63:0] ea [3];
        int          doneCyc;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic s1, input logic s2, input logic d,
                                input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] ad,
                                input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] rd,
                                input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] ed,
                                input int nReq, input logic [63:0] x0, input logic [63:0] x1,
                                input logic [63:0] x2, input int doneCyc);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.d = d;
        v.a1 = a1; v.a2 = a2; v.ad = ad;
        v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.e1 = e1; v.e2 = e2; v.ed = ed;
        v.nReq = nReq; v.ea[0] = x0; v.ea[1] = x1; v.ea[2] = x2;
        v.doneCyc = doneCyc;
        return v;
    endfunction

    function automatic logic [63:0] memWord(input logic [63:0] a);
        case (a)
            64'h100:  return MEM_A;
            64'h200:  return MEM_B;
            64'h300:  return MEM_C;
            64'h1000: return MEM_E;
            default:  return 64'hBADB_AD00_0000_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveOp(input logic s1, input logic s2, input logic d,
                           input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] ad,
                           input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] rd);
        isMemoryAccessSrc1In = s1; isMemoryAccessSrc2In = s2; isMemoryAccessDestIn = d;
        memoryAddressSrc1In = a1; memoryAddressSrc2In = a2; memoryAddressDestIn = ad;
        operand1ValIn = r1; operand2ValIn = r2; destRegValueIn = rd;
    endtask

    // One instruction against a zero-wait memory; records the request order and done latency.
    task automatic runFetch(input vec_t v, input string tag);
        logic [63:0] reqLog [3];
        int          nReq = 0;
        int          cyc = 1;
        bit          respNext = 1'b0;
        bit          done = 1'b0;
        logic [63:0] pend = '0;
        reqLog[0] = '0; reqLog[1] = '0; reqLog[2] = '0;
        driveOp(v.s1, v.s2, v.d, v.a1, v.a2, v.ad, v.r1, v.r2, v.rd);
        stallIn = 1'b0; memReadyIn = 1'b1; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        check({tag, " stallOut after accept"}, stallOut, 1'b1);
        while (!done && cyc < 40) begin
            memDataValidIn = 1'b0;
            if (respNext) begin
                memDataValidIn = 1'b1;
                memDataIn = memWord(pend);
                respNext = 1'b0;
            end
            if (fetchDoneOut) done = 1'b1;
            else if (memReqOut) begin
                if (nReq < 3) reqLog[nReq] = memAddrOut;
                nReq++;
                pend = memAddrOut;
                respNext = 1'b1;
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        memDataValidIn = 1'b0;
        check({tag, " reached done"}, done, 1'b1);
        check({tag, " done cycle"}, cyc, v.doneCyc);
        check({tag, " request count"}, nReq, v.nReq);
        for (int i = 0; i < v.nReq && i < 3; i++)
            check($sformatf("%s request %0d address", tag, i), reqLog[i], v.ea[i]);
        check({tag, " operand1"}, operand1ValOut, v.e1);
        check({tag, " operand2"}, operand2ValOut, v.e2);
        check({tag, " dest"}, destMemValueOut, v.ed);
        tick();
        check({tag, " fetchDone drops"}, fetchDoneOut, 1'b0);
        check({tag, " stallOut drops"}, stallOut, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(0, 0, 0, 64'h0,   64'h0,   64'h0,    64'h11, 64'h22, 64'h33,
                     64'h11, 64'h22, 64'h33, 0, 64'h0, 64'h0, 64'h0, 1);
        vecs[1] = mk(1, 1, 1, 64'h100, 64'h200, 64'h300,  64'h1, 64'h2, 64'h3,
                     MEM_A, MEM_B, MEM_C, 3, 64'h100, 64'h200, 64'h300, 7);
        vecs[2] = mk(0, 1, 0, 64'h100, 64'h200, 64'h300,  64'h5, 64'h6, 64'h7,
                     64'h5, MEM_B, 64'h7, 1, 64'h200, 64'h0, 64'h0, 3);
        vecs[3] = mk(1, 0, 1, 64'h100, 64'h200, 64'h300,  64'h8, 64'h9, 64'hA,
                     MEM_A, 64'h9, MEM_C, 2, 64'h100, 64'h300, 64'h0, 5);
        vecs[4] = mk(0, 0, 1, 64'h100, 64'h200, 64'h1000, 64'hB, 64'hC, 64'hD,
                     64'hB, 64'hC, MEM_E, 1, 64'h1000, 64'h0, 64'h0, 3);

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("reset stallOut", stallOut, 1'b0);
        check("reset memReqOut", memReqOut, 1'b0);
        check("reset fetchDoneOut", fetchDoneOut, 1'b0);
        check("reset fetchErrorOut", fetchErrorOut, 1'b0);
        check("reset operand1", operand1ValOut, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++)
            runFetch(vecs[i], $sformatf("vec%0d", i));

        // Src1 with ready delayed 3 cycles; data offered in the acceptance cycle is ignored
        driveOp(1, 0, 0, 64'h1000, 64'h0, 64'h0, 64'h11, 64'h22, 64'h33);
        memReadyIn = 1'b0; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("delayed req %0d memReqOut", i), memReqOut, 1'b1);
            check($sformatf("delayed req %0d memAddrOut", i), memAddrOut, 64'h1000);
            if (i == 4) begin
                memReadyIn = 1'b1;
                memDataValidIn = 1'b1;
                memDataIn = 64'h0BAD;
            end
            tick();
        end
        check("delayed memReqOut after accept", memReqOut, 1'b0);
        memReadyIn = 1'b0;
        memDataIn = MEM_E;
        tick();
        memDataValidIn = 1'b0;
        check("delayed fetchDone", fetchDoneOut, 1'b1);
        check("delayed operand1", operand1ValOut, MEM_E);
        check("delayed operand2 passthrough", operand2ValOut, 64'h22);
        check("delayed dest passthrough", destMemValueOut, 64'h33);

        // Hold DONE with stallIn for 5 cycles while a new instruction waits on validIn
        stallIn = 1'b1;
        driveOp(0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h77, 64'h88, 64'h99);
        validIn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall %0d fetchDone", i), fetchDoneOut, 1'b1);
            check($sformatf("stall %0d operand1", i), operand1ValOut, MEM_E);
            check($sformatf("stall %0d operand2", i), operand2ValOut, 64'h22);
            check($sformatf("stall %0d stallOut", i), stallOut, 1'b1);
        end
        stallIn = 1'b0;
        tick();
        check("release fetchDone falls", fetchDoneOut, 1'b0);
        check("release stallOut idle", stallOut, 1'b0);
        tick();
        validIn = 1'b0;
        check("next instr fetchDone", fetchDoneOut, 1'b1);
        check("next instr operand1", operand1ValOut, 64'h77);
        check("next instr operand2", operand2ValOut, 64'h88);
        tick();
        check("next instr back to idle", fetchDoneOut, 1'b0);

        // Memory accepts but never answers: timeout abort after 8 cycles in WT
        driveOp(1, 0, 0, 64'h100, 64'h0, 64'h0, 64'h1, 64'h2, 64'h3);
        memReadyIn = 1'b1; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("timeout c%0d fetchError", c), fetchErrorOut, (c == 10) ? 1'b1 : 1'b0);
            check($sformatf("timeout c%0d fetchDone", c), fetchDoneOut, 1'b0);
            if (c == 10) begin
                check("timeout stallOut idle", stallOut, 1'b0);
                check("timeout memReqOut", memReqOut, 1'b0);
            end
            tick();
        end

        // Asynchronous reset while waiting on src2; the late response must be dropped
        driveOp(1, 1, 0, 64'h100, 64'h200, 64'h0, 64'h1, 64'h2, 64'h3);
        memReadyIn = 1'b1; validIn = 1'b1;
        tick();
        validIn = 1'b0;
        tick();
        memDataValidIn = 1'b1; memDataIn = MEM_A;
        tick();
        memDataValidIn = 1'b0;
        check("pre-reset memReqOut", memReqOut, 1'b1);
        check("pre-reset memAddrOut", memAddrOut, 64'h200);
        tick();
        check("pre-reset operand1", operand1ValOut, MEM_A);
        check("pre-reset stallOut", stallOut, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset stallOut", stallOut, 1'b0);
        check("async reset operand1", operand1ValOut, 64'h0);
        check("async reset memReqOut", memReqOut, 1'b0);
        check("async reset memAddrOut", memAddrOut, 64'h0);
        check("async reset fetchDone", fetchDoneOut, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        memDataValidIn = 1'b1; memDataIn = MEM_B;
        tick();
        memDataValidIn = 1'b0;
        check("late data stallOut", stallOut, 1'b0);
        check("late data operand2", operand2ValOut, 64'h0);
        check("late data fetchDone", fetchDoneOut, 1'b0);
        runFetch(vecs[1], "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
